// File: rtl/layer_1_sequencer.sv
// Sequences one layer-1 inference pass: bias preload, NUM_STEPS accumulate beats, done-echo check, result hold.
// Latency: start to result_valid is NUM_STEPS+3 cycles minimum; one beat per cycle in ACCUM.
// Backpressure: in_ready high only in ACCUM; result held frozen in DONE until result_ack.
module layer_1_sequencer #(
    parameter int NUM_STEPS = 256,
    parameter int CNT_WIDTH = 9
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    output logic                 o_acc_reset,
    output logic                 o_acc_load,
    input  logic                 i_acc_done,
    output logic [CNT_WIDTH-1:0] o_step_idx,
    output logic                 o_busy,
    output logic                 o_result_valid,
    input  logic                 i_result_ack,
    output logic                 o_seq_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(NUM_STEPS - 1);
    localparam logic [CNT_WIDTH:0]   NUM_BEATS = (CNT_WIDTH + 1)'(NUM_STEPS);
    localparam logic [CNT_WIDTH:0]   ONE_BEAT  = (CNT_WIDTH + 1)'(1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_step_idx;
    logic [CNT_WIDTH:0]   r_done_cnt;
    logic                 r_drain_cnt;   // set after the first DRAIN cycle without an echo
    logic                 r_seq_err;

    logic w_start_go;
    logic w_last_beat;
    logic w_drain_echo;
    logic w_drain_timeout;
    logic w_cnt_mismatch;

    // Shared decode used by both the next-state logic and the datapath registers
    always_comb begin
        w_start_go      = (r_state == S_IDLE) && i_start && !i_abort;
        w_last_beat     = o_acc_load && (r_step_idx == LAST_IDX);
        w_drain_echo    = (r_state == S_DRAIN) && i_acc_done;
        w_drain_timeout = (r_state == S_DRAIN) && !i_acc_done && r_drain_cnt;
        // The echo arriving in DRAIN is the last one, so count it before comparing
        w_cnt_mismatch  = (r_done_cnt + ONE_BEAT) != NUM_BEATS;
    end

    // State register; reset wins over everything, including a pass in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_go) w_next = S_CLEAR;
            S_CLEAR: w_next = S_ACCUM;
            S_ACCUM: if (w_last_beat) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_echo || w_drain_timeout) w_next = S_DONE;
            S_DONE:  if (i_result_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    // Outputs are Moore decodes of state except acc_load, which follows in_valid the same cycle
    always_comb begin
        o_in_ready     = (r_state == S_ACCUM);
        o_acc_load     = i_in_valid && (r_state == S_ACCUM);
        o_acc_reset    = i_reset || (r_state == S_CLEAR);
        o_busy         = (r_state != S_IDLE);
        o_result_valid = (r_state == S_DONE);
        o_step_idx     = r_step_idx;
        o_seq_err      = r_seq_err;
    end

    // Step/echo counters and the sticky error flag; all cleared when a pass is launched
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_step_idx  <= '0;
            r_done_cnt  <= '0;
            r_drain_cnt <= 1'b0;
            r_seq_err   <= 1'b0;
        end else if (w_start_go) begin
            r_step_idx  <= '0;
            r_done_cnt  <= '0;
            r_drain_cnt <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            // A beat offered in an abort cycle is still taken, so abort does not gate this
            if (o_acc_load) begin
                r_step_idx <= w_last_beat ? '0 : r_step_idx + 1'b1;
            end
            if (((r_state == S_ACCUM) || (r_state == S_DRAIN)) && i_acc_done) begin
                r_done_cnt <= r_done_cnt + ONE_BEAT;
            end
            if ((r_state == S_DRAIN) && !i_acc_done) begin
                r_drain_cnt <= 1'b1;
            end
            // An aborted pass leaves the error flag as it was
            if (!i_abort && ((w_drain_echo && w_cnt_mismatch) || w_drain_timeout)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_1_sequencer.sv
// Directed bench for layer_1_sequencer with NUM_STEPS=4 and a behavioural accumulator attached.
// Latency: each step advances one clock; outputs are checked 1-2 ns after the rising edge.
// Backpressure: in_valid bubbles and a stubbed acc_done echo are driven from the bench.
module tb_layer_1_sequencer;

    localparam int NS   = 4;
    localparam int CW   = 3;
    localparam int BIAS = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          acc_reset;
    logic          acc_load;
    logic          acc_done;
    logic [CW-1:0] step_idx;
    logic          busy;
    logic          result_valid;
    logic          result_ack;
    logic          seq_err;

    logic          done_en;   // when low, the echo of this cycle's load is dropped
    logic [15:0]   pdata;
    logic [15:0]   acc;

    int tests = 0;
    int fails = 0;

    layer_1_sequencer #(.NUM_STEPS(NS), .CNT_WIDTH(CW)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_abort        (abort),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .o_acc_reset    (acc_reset),
        .o_acc_load     (acc_load),
        .i_acc_done     (acc_done),
        .o_step_idx     (step_idx),
        .o_busy         (busy),
        .o_result_valid (result_valid),
        .i_result_ack   (result_ack),
        .o_seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    // Accumulator stand-in: bias preload on acc_reset, add on load, registered done echo
    always @(posedge clk) begin
        acc_done <= acc_load & done_en;
        if (acc_reset) acc <= 16'(BIAS);
        else if (acc_load) acc <= acc + pdata;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int n;

        // ---- reset, with start held high (must be ignored)
        reset = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1;
        result_ack = 1'b0; done_en = 1'b1; pdata = '0;
        cyc(); cyc();
        chk("rst_acc_reset", acc_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_acc_load", acc_load, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_step_idx", step_idx, 0);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        cyc();
        chk("rst_start_ignored", busy, 0);
        chk("idle_acc_reset", acc_reset, 0);

        // ---- normal pass, in_valid held high: beats 3,5,7,9
        in_valid = 1'b1; start = 1'b1;
        cyc(); start = 1'b0;                       // T+1 CLEAR
        chk("t1_clear_acc_reset", acc_reset, 1);
        chk("t1_clear_busy", busy, 1);
        chk("t1_clear_no_load", acc_load, 0);
        cyc();                                     // T+2 first beat
        for (int i = 0; i < NS; i++) begin
            pdata = 16'(3 + 2 * i);
            chk("t1_load", acc_load, 1);
            chk("t1_step_idx", step_idx, i);
            cyc();
        end
        chk("t1_drain_rv", result_valid, 0);       // T+6 DRAIN
        chk("t1_drain_ready", in_ready, 0);
        chk("t1_drain_echo", acc_done, 1);
        cyc();                                     // T+7 DONE
        chk("t1_done_rv", result_valid, 1);
        chk("t1_done_err", seq_err, 0);
        chk("t1_done_load", acc_load, 0);
        chk("t1_acc_value", acc, BIAS + 24);
        result_ack = 1'b1;
        cyc(); result_ack = 1'b0; in_valid = 1'b0;
        chk("t1_ack_rv", result_valid, 0);
        chk("t1_ack_busy", busy, 0);

        // ---- bubble pattern 1,0,0,1,1,0,1: beats 1,2,3,4
        start = 1'b1;
        cyc(); start = 1'b0;                       // CLEAR
        cyc();                                     // ACCUM
        n = 0;
        for (int k = 0; k < 7; k++) begin
            in_valid = pat[k];
            pdata = 16'(n + 1);
            #1;
            chk("t2_step_idx", step_idx, n);
            chk("t2_load", acc_load, pat[k]);
            if (pat[k]) n++;
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("t2_load_count", n, NS);
        chk("t2_drain_rv", result_valid, 0);
        chk("t2_drain_busy", busy, 1);
        cyc();
        chk("t2_done_rv", result_valid, 1);
        chk("t2_done_err", seq_err, 0);
        chk("t2_step_wrap", step_idx, 0);
        chk("t2_acc_value", acc, BIAS + 10);
        result_ack = 1'b1;
        cyc(); result_ack = 1'b0;

        // ---- echo of the 2nd beat dropped -> count mismatch
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        for (int i = 0; i < NS; i++) begin
            in_valid = 1'b1; pdata = 16'd10; done_en = (i != 1);
            #1;
            chk("t3_load", acc_load, 1);
            cyc();
        end
        in_valid = 1'b0; done_en = 1'b1;
        #1;
        chk("t3_drain_err", seq_err, 0);
        cyc();
        chk("t3_done_rv", result_valid, 1);
        chk("t3_done_err", seq_err, 1);
        result_ack = 1'b1;
        cyc(); result_ack = 1'b0;
        chk("t3_idle_err_sticky", seq_err, 1);

        // ---- next start clears the error; abort after 2 beats
        start = 1'b1;
        cyc(); start = 1'b0;
        chk("t5_start_clears_err", seq_err, 0);
        chk("t5_clear_acc_reset", acc_reset, 1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; pdata = 16'(50 + 10 * i);
            #1;
            chk("t5_step_idx", step_idx, i);
            cyc();
        end
        in_valid = 1'b0; abort = 1'b1;
        #1;
        chk("t5_abort_cycle_busy", busy, 1);
        cyc(); abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_ready", in_ready, 0);
        chk("t5_abort_rv", result_valid, 0);
        chk("t5_abort_err", seq_err, 0);

        // ---- fresh pass after abort: beats 20..23
        start = 1'b1;
        cyc(); start = 1'b0;
        chk("t5b_preload", acc_reset, 1);
        cyc();
        chk("t5b_preload_value", acc, BIAS);
        for (int i = 0; i < NS; i++) begin
            in_valid = 1'b1; pdata = 16'(20 + i);
            #1;
            chk("t5b_step_idx", step_idx, i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("t5b_done_rv", result_valid, 1);
        chk("t5b_done_err", seq_err, 0);
        chk("t5b_acc_value", acc, BIAS + 86);
        result_ack = 1'b1;
        cyc(); result_ack = 1'b0;

        // ---- last echo never arrives -> two DRAIN cycles then timeout error
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        for (int i = 0; i < NS; i++) begin
            in_valid = 1'b1; pdata = 16'd1; done_en = (i != NS - 1);
            cyc();
        end
        in_valid = 1'b0; done_en = 1'b1;
        #1;
        chk("t4_drain1_rv", result_valid, 0);
        chk("t4_drain1_busy", busy, 1);
        cyc();
        chk("t4_drain2_rv", result_valid, 0);
        chk("t4_drain2_err", seq_err, 0);
        cyc();
        chk("t4_done_rv", result_valid, 1);
        chk("t4_done_err", seq_err, 1);
        cyc();
        chk("t4_done_hold", result_valid, 1);

        // ---- reset in DONE without ack, start asserted alongside reset
        reset = 1'b1; start = 1'b1; in_valid = 1'b1;
        #1;
        chk("t6_acc_reset_in_done", acc_reset, 1);
        cyc();
        chk("t6_rst_acc_reset", acc_reset, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rv", result_valid, 0);
        chk("t6_rst_err", seq_err, 0);
        chk("t6_rst_step_idx", step_idx, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_load", acc_load, 0);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        cyc();
        chk("t6_start_ignored", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
